// File: rtl/fmap_serializer.sv
// fmap_serializer: snapshots one pooled feature-map frame (CHANNELS x DIM x DIM,
// 1-bit pixels) and streams it out one channel per valid/ready beat.
// Optional feature macro: FMAP_SER_PARITY_EN adds the m_parity output.
module fmap_serializer #(
   parameter  int unsigned CHANNELS = 60,
   parameter  int unsigned DIM      = 4,
   parameter  int unsigned CNT_W    = 16,
   localparam int unsigned BEAT_W   = DIM * DIM,
   localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [0:CHANNELS-1][0:DIM-1][0:DIM-1]  fmaps_in,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic [BEAT_W-1:0]                      m_data,
   output logic [CH_W-1:0]                        m_chan,
   output logic                                   m_valid,
   output logic                                   m_last,
   input  logic                                   m_ready,
   output logic                                   busy,
`ifdef FMAP_SER_PARITY_EN
   output logic                                   m_parity,
`endif
   output logic [CNT_W-1:0]                       frame_cnt
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                                state;
   logic [0:CHANNELS-1][0:DIM-1][0:DIM-1] snap;
   logic [CH_W-1:0]                       nxt_chan;

   // Flatten one channel so that pixel [r][c] lands on bit r*DIM+c.
   function automatic logic [BEAT_W-1:0] pack_chan(input logic [0:DIM-1][0:DIM-1] ch);
      logic [BEAT_W-1:0] p;
      p = '0;
      for (int unsigned r = 0; r < DIM; r++) begin
         for (int unsigned c = 0; c < DIM; c++) begin
            p[r*DIM+c] = ch[r][c];
         end
      end
      return p;
   endfunction

   // The frame is only accepted while idle; upstream sees this without a register stage.
   assign in_ready = (state == IDLE);
   assign nxt_chan = m_chan + CH_W'(1);

`ifdef FMAP_SER_PARITY_EN
   // Parity qualifies the current beat only; forced low whenever no beat is presented.
   assign m_parity = m_valid ? (^m_data) : 1'b0;
`endif

   // Frame sequencer: accept/snapshot in IDLE, walk channels in SEND, hold on backpressure.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         snap      <= '0;
         m_chan    <= '0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         busy      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  snap    <= fmaps_in;
                  m_chan  <= '0;
                  m_data  <= pack_chan(fmaps_in[0]);
                  m_valid <= 1'b1;
                  m_last  <= (CHANNELS == 1);
                  busy    <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (m_ready) begin
                  if (m_last) begin
                     state     <= IDLE;
                     m_chan    <= '0;
                     m_data    <= '0;
                     m_valid   <= 1'b0;
                     m_last    <= 1'b0;
                     busy      <= 1'b0;
                     frame_cnt <= frame_cnt + CNT_W'(1);
                  end else begin
                     m_chan <= nxt_chan;
                     m_data <= pack_chan(snap[nxt_chan]);
                     m_last <= (nxt_chan == CH_W'(CHANNELS - 1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fmap_serializer.sv
// Scoreboard bench for fmap_serializer: stimulus pushes expected beats, monitor pops on handshake.
module tb_fmap_serializer;

   localparam int unsigned CH  = 60;
   localparam int unsigned D   = 4;
   localparam int unsigned CW  = 16;

   typedef logic [0:CH-1][0:D-1][0:D-1] frame_t;
   typedef struct {
      logic [5:0]  chan;
      logic [15:0] data;
      logic        last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   frame_t        fmaps_in;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   m_data;
   logic [5:0]    m_chan;
   logic          m_valid;
   logic          m_last;
   logic          m_ready;
   logic          busy;
   logic [CW-1:0] frame_cnt;
`ifdef FMAP_SER_PARITY_EN
   logic          m_parity;
`endif

   beat_t       q[$];
   logic [15:0] exp_w [CH];
   logic [15:0] w_b   [CH];
   logic [15:0] w_c   [CH];
   frame_t      fr_b;
   frame_t      fr_c;
   int          n_vec = 0;
   int          n_err = 0;

   fmap_serializer #(.CHANNELS(CH), .DIM(D), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fmaps_in  (fmaps_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .m_data    (m_data),
      .m_chan    (m_chan),
      .m_valid   (m_valid),
      .m_last    (m_last),
      .m_ready   (m_ready),
      .busy      (busy),
`ifdef FMAP_SER_PARITY_EN
      .m_parity  (m_parity),
`endif
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // Pixel [r][c] of channel ch comes from bit r*D+c of word w.
   function automatic frame_t frame_from(input logic [15:0] w [CH]);
      frame_t f;
      for (int ch = 0; ch < CH; ch++)
         for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++)
               f[ch][r][c] = w[ch][r*D+c];
      return f;
   endfunction

   task automatic push_frame(input logic [15:0] w [CH]);
      beat_t b;
      for (int ch = 0; ch < CH; ch++) begin
         b.chan = 6'(ch);
         b.data = w[ch];
         b.last = (ch == CH - 1);
         q.push_back(b);
      end
   endtask

   task automatic wait_last();
      bit seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (m_valid && m_ready && m_last) begin
            seen = 1;
            break;
         end
      end
      check("last_beat_seen", 32'(seen), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_chan(input logic [5:0] target);
      bit seen = 0;
      for (int i = 0; i < 300; i++) begin
         if (m_valid && m_chan == target) begin
            seen = 1;
            break;
         end
         @(posedge clk); #1;
      end
      check("reach_chan", 32'(seen), 32'd1);
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && m_valid && m_ready) begin
            if (q.size() == 0) begin
               check("unexpected_beat", 32'(m_chan), 32'hFFFF_FFFF);
            end else begin
               e = q.pop_front();
               check("beat_chan", 32'(m_chan), 32'(e.chan));
               check("beat_data", 32'(m_data), 32'(e.data));
               check("beat_last", 32'(m_last), 32'(e.last));
`ifdef FMAP_SER_PARITY_EN
               check("beat_parity", 32'(m_parity), 32'($countones(e.data) % 2));
`endif
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got running, want done");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t fa;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      m_ready  = 1'b1;
      fmaps_in = '0;

      // 1: reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_m_chan", 32'(m_chan), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2: ch0 all ones, ch5 only pixel [1][2]
      fa = '0;
      for (int r = 0; r < D; r++)
         for (int c = 0; c < D; c++)
            fa[0][r][c] = 1'b1;
      fa[5][1][2] = 1'b1;
      for (int ch = 0; ch < CH; ch++) exp_w[ch] = 16'h0000;
      exp_w[0] = 16'hFFFF;
      exp_w[5] = 16'h0040;
      fmaps_in = fa;
      in_valid = 1'b1;
      @(posedge clk);
      push_frame(exp_w);
      #1;
      in_valid = 1'b0;
      check("a_first_valid", 32'(m_valid), 32'd1);
      check("a_first_chan", 32'(m_chan), 32'd0);
      check("a_first_data", 32'(m_data), 32'hFFFF);
      check("a_busy", 32'(busy), 32'd1);
      check("a_in_ready_low", 32'(in_ready), 32'd0);
      wait_last();
      check("a_in_ready_after", 32'(in_ready), 32'd1);
      check("a_valid_after", 32'(m_valid), 32'd0);
      check("a_busy_after", 32'(busy), 32'd0);
      check("a_frame_cnt", 32'(frame_cnt), 32'd1);

      // 3+4: stall at channel 10, new frame presented and held during SEND
      for (int ch = 0; ch < CH; ch++) begin
         w_b[ch] = 16'(ch * 16'h0103 + 1);
         w_c[ch] = 16'(16'hF00F ^ (ch * 16'h0011));
      end
      fr_b = frame_from(w_b);
      fr_c = frame_from(w_c);
      fmaps_in = fr_b;
      in_valid = 1'b1;
      @(posedge clk);
      push_frame(w_b);
      #1;
      fmaps_in = fr_c;
      wait_chan(6'd10);
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("stall_chan", 32'(m_chan), 32'd10);
         check("stall_data", 32'(m_data), 32'(w_b[10]));
         check("stall_valid", 32'(m_valid), 32'd1);
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      check("resume_next_chan", 32'(m_chan), 32'd11);
      check("resume_next_data", 32'(m_data), 32'(w_b[11]));
      wait_last();
      check("b_in_ready_after", 32'(in_ready), 32'd1);
      check("b_frame_cnt", 32'(frame_cnt), 32'd2);
      push_frame(w_c);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("c_first_chan", 32'(m_chan), 32'd0);
      check("c_first_data", 32'(m_data), 32'(w_c[0]));
      wait_last();
      check("c_frame_cnt", 32'(frame_cnt), 32'd3);

      // 5: reset in the middle of a frame
      fmaps_in = fr_b;
      in_valid = 1'b1;
      @(posedge clk);
      push_frame(w_b);
      #1;
      in_valid = 1'b0;
      wait_chan(6'd30);
      rst_n = 1'b0;
      q.delete();
      @(posedge clk); #1;
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_chan", 32'(m_chan), 32'd0);
      check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FMAP_SER_PARITY_EN
      check("mid_rst_parity", 32'(m_parity), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 6: frame with a 3-ones channel and an all-ones channel
      for (int ch = 0; ch < CH; ch++) exp_w[ch] = 16'(ch);
      exp_w[1] = 16'h0007;
      exp_w[2] = 16'hFFFF;
      fmaps_in = frame_from(exp_w);
      in_valid = 1'b1;
      @(posedge clk);
      push_frame(exp_w);
      #1;
      in_valid = 1'b0;
      check("e_first_chan", 32'(m_chan), 32'd0);
      wait_chan(6'd1);
      check("e_ch1_data", 32'(m_data), 32'h0007);
`ifdef FMAP_SER_PARITY_EN
      check("e_ch1_parity", 32'(m_parity), 32'd1);
`endif
      wait_chan(6'd2);
      check("e_ch2_data", 32'(m_data), 32'hFFFF);
`ifdef FMAP_SER_PARITY_EN
      check("e_ch2_parity", 32'(m_parity), 32'd0);
`endif
      wait_last();
      check("e_frame_cnt", 32'(frame_cnt), 32'd1);
      check("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
